// File: rtl/time_counter_pkg.sv
// Shared definitions for the time-keeping core and its downstream hour converter.
//   - Field widths and limits (HR_W/MS_W, HR_MAX/MS_MAX)
//   - Set-mode state encoding and the mode_btn state sequence
// Build option: define ALARM_EN to add the alarm set states (mode widens to 3 bits).
package time_counter_pkg;

  localparam int unsigned HR_W   = 5;
  localparam int unsigned MS_W   = 6;
  localparam int unsigned HR_MAX = 23;
  localparam int unsigned MS_MAX = 59;

`ifdef ALARM_EN
  localparam int unsigned MODE_W = 3;
`else
  localparam int unsigned MODE_W = 2;
`endif

  typedef enum logic [MODE_W-1:0] {
    StRun     = MODE_W'(0),
    StSetHr   = MODE_W'(1),
`ifdef ALARM_EN
    StSetMin  = MODE_W'(2),
    StSetAhr  = MODE_W'(3),
    StSetAmin = MODE_W'(4)
`else
    StSetMin  = MODE_W'(2)
`endif
  } state_e;

  // Last set state; mode_btn here returns to RUN and clears the seconds.
`ifdef ALARM_EN
  localparam state_e StLast = StSetAmin;
`else
  localparam state_e StLast = StSetMin;
`endif

  function automatic state_e next_state(state_e s);
    state_e n;
    case (s)
      StRun:     n = StSetHr;
      StSetHr:   n = StSetMin;
`ifdef ALARM_EN
      StSetMin:  n = StSetAhr;
      StSetAhr:  n = StSetAmin;
`endif
      default:   n = StRun;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/time_counter_if.sv
// Button/tick inputs and time outputs of the time-keeping core.
//   master: drives tick, mode_btn, inc_btn; observes the time fields
//   slave : the core; drives hour, minute, second, mode, day_pulse (and alarm)
// Build option: ALARM_EN adds the alarm signal.
interface time_counter_if;
  import time_counter_pkg::*;

  logic              tick;
  logic              mode_btn;
  logic              inc_btn;
  logic [HR_W-1:0]   hour;
  logic [MS_W-1:0]   minute;
  logic [MS_W-1:0]   second;
  logic [MODE_W-1:0] mode;
  logic              day_pulse;
`ifdef ALARM_EN
  logic              alarm;
`endif

  modport master (
    output tick, mode_btn, inc_btn,
`ifdef ALARM_EN
    input  alarm,
`endif
    input  hour, minute, second, mode, day_pulse
  );

  modport slave (
    input  tick, mode_btn, inc_btn,
`ifdef ALARM_EN
    output alarm,
`endif
    output hour, minute, second, mode, day_pulse
  );

endinterface

// File: rtl/time_counter_wrap_counter.sv
// Modulo-(Max+1) counter used for every time and alarm field.
//   clk, rst           : clock, synchronous active-high reset (loads RstVal)
//   inc                : advance by one, Max wraps to 0
//   load, load_val     : synchronous load, higher priority than inc
//   value              : registered field value
//   next_value         : value that will be registered at the next edge (rst excluded)
//   carry              : inc while at Max (combinational)
module time_counter_wrap_counter #(
  parameter int unsigned Width  = 6,
  parameter int unsigned Max    = 59,
  parameter int unsigned RstVal = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic [Width-1:0] value,
  output logic [Width-1:0] next_value,
  output logic             carry
);

  logic [Width-1:0] value_q, value_d;
  logic             at_max;

  assign at_max = (value_q == Width'(Max));
  assign carry  = inc && at_max;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (inc) begin
      value_d = at_max ? '0 : value_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= Width'(RstVal);
    end else begin
      value_q <= value_d;
    end
  end

  assign value      = value_q;
  assign next_value = value_d;

endmodule

// File: rtl/time_counter.sv
// Hour/minute/second time-keeping core with button-driven set mode.
//   clk, rst : clock, synchronous active-high reset (loads INIT_HR:INIT_MIN:00, RUN)
//   bus      : slave side of time_counter_if (tick, mode_btn, inc_btn in;
//              hour, minute, second, mode, day_pulse, alarm out)
// Build option: ALARM_EN adds alarm hour/minute registers, two extra set states and
// the alarm output.
module time_counter
  import time_counter_pkg::*;
#(
  parameter int unsigned INIT_HR  = 0,
  parameter int unsigned INIT_MIN = 0
) (
  input logic           clk,
  input logic           rst,
  time_counter_if.slave bus
);

  if (INIT_HR > HR_MAX) begin : g_bad_init_hr
    $error("INIT_HR out of range 0..23");
  end
  if (INIT_MIN > MS_MAX) begin : g_bad_init_min
    $error("INIT_MIN out of range 0..59");
  end

  state_e          state_q, state_d;
  logic            day_pulse_q;
  logic            in_run, inc_ok;
  logic            sec_inc, sec_load, sec_carry;
  logic            min_inc, min_carry;
  logic            hr_inc, hr_carry;
  logic [HR_W-1:0] hr_next;
  logic [MS_W-1:0] min_next;
  logic [MS_W-1:0] unused_sec_next;

  assign in_run  = (state_q == StRun);
  // A mode press wins over a same-cycle increment.
  assign inc_ok  = bus.inc_btn && !bus.mode_btn;
  assign state_d = bus.mode_btn ? next_state(state_q) : state_q;

  assign sec_inc  = in_run && bus.tick;
  assign sec_load = bus.mode_btn && (state_q == StLast);
  assign min_inc  = (in_run && sec_carry) || ((state_q == StSetMin) && inc_ok);
  // Hour only takes a carry in RUN, so a set-mode minute wrap never reaches it.
  assign hr_inc   = (in_run && min_carry) || ((state_q == StSetHr) && inc_ok);

  time_counter_wrap_counter #(.Width(MS_W), .Max(MS_MAX), .RstVal(0)) u_sec (
    .clk        (clk),
    .rst        (rst),
    .inc        (sec_inc),
    .load       (sec_load),
    .load_val   ('0),
    .value      (bus.second),
    .next_value (unused_sec_next),
    .carry      (sec_carry)
  );

  time_counter_wrap_counter #(.Width(MS_W), .Max(MS_MAX), .RstVal(INIT_MIN)) u_min (
    .clk        (clk),
    .rst        (rst),
    .inc        (min_inc),
    .load       (1'b0),
    .load_val   ('0),
    .value      (bus.minute),
    .next_value (min_next),
    .carry      (min_carry)
  );

  time_counter_wrap_counter #(.Width(HR_W), .Max(HR_MAX), .RstVal(INIT_HR)) u_hr (
    .clk        (clk),
    .rst        (rst),
    .inc        (hr_inc),
    .load       (1'b0),
    .load_val   ('0),
    .value      (bus.hour),
    .next_value (hr_next),
    .carry      (hr_carry)
  );

`ifdef ALARM_EN
  logic            alarm_q;
  logic [HR_W-1:0] alm_hr_next;
  logic [MS_W-1:0] alm_min_next;
  logic [HR_W-1:0] alm_hr;
  logic [MS_W-1:0] alm_min;
  logic            unused_ahr_carry, unused_amin_carry;

  time_counter_wrap_counter #(.Width(HR_W), .Max(HR_MAX), .RstVal(0)) u_alm_hr (
    .clk        (clk),
    .rst        (rst),
    .inc        ((state_q == StSetAhr) && inc_ok),
    .load       (1'b0),
    .load_val   ('0),
    .value      (alm_hr),
    .next_value (alm_hr_next),
    .carry      (unused_ahr_carry)
  );

  time_counter_wrap_counter #(.Width(MS_W), .Max(MS_MAX), .RstVal(0)) u_alm_min (
    .clk        (clk),
    .rst        (rst),
    .inc        ((state_q == StSetAmin) && inc_ok),
    .load       (1'b0),
    .load_val   ('0),
    .value      (alm_min),
    .next_value (alm_min_next),
    .carry      (unused_amin_carry)
  );

  logic unused_alm_q;
  assign unused_alm_q = ^{alm_hr, alm_min};
  assign bus.alarm    = alarm_q;
`else
  logic unused_next;
  assign unused_next = ^{hr_next, min_next};
`endif

  // hr_carry in RUN only happens on the full 23:59:59 rollover.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      day_pulse_q <= 1'b0;
`ifdef ALARM_EN
      alarm_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      day_pulse_q <= in_run && hr_carry;
`ifdef ALARM_EN
      // Compare next-state values so alarm lines up with the fields it describes.
      alarm_q     <= (state_d == StRun) && (hr_next == alm_hr_next)
                     && (min_next == alm_min_next);
`endif
    end
  end

  assign bus.mode      = state_q;
  assign bus.day_pulse = day_pulse_q;

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- Hour/minute/second time-keeping core of the digital clock.
- Sits directly upstream of the hour-to-display converter. Its 5-bit binary hour (0–23) is that converter's input value.
- Advances on a 1 Hz enable pulse from the frequency divider.
- Provides a button-driven set-mode state machine for adjusting hour and minute.

Parameters:
- INIT_HR, 0, hour loaded at reset (0–23).
- INIT_MIN, 0, minute loaded at reset (0–59).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  1-cycle enable, one per second.
- mode_btn  input  1  debounced one-pulse; advances set-mode state.
- inc_btn  input  1  debounced one-pulse; increments the selected field.
- hour  output  5  binary hour 0–23.
- minute  output  6  binary minute 0–59.
- second  output  6  binary second 0–59.
- mode  output  2  current state encoding (for blink/indicator logic).
- day_pulse  output  1  1-cycle pulse on 23:59:59 -> 00:00:00 rollover.
- alarm  output  1  present only with ALARM_EN.

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - hour=INIT_HR, minute=INIT_MIN, second=0.
  - State=RUN (mode=2'd0), day_pulse=0.
  - rst has priority over every other input.
  - Mid-set-mode reset returns to RUN with the INIT values.
- All outputs are registered. Field updates are visible the cycle after the triggering input.
- States: RUN=0, SET_HR=1, SET_MIN=2. mode_btn cycles RUN->SET_HR->SET_MIN->RUN.
- RUN:
  - Each tick increments second.
  - second 59->0 carries into minute; minute 59->0 carries into hour; hour 23->0.
  - All carries resolve in the same cycle.
  - day_pulse=1 for exactly the cycle after the tick that wraps 23:59:59 to 00:00:00.
- SET_HR:
  - tick ignored; seconds frozen.
  - inc_btn: hour+1, 23->0 wrap. No other field changes.
- SET_MIN:
  - tick ignored.
  - inc_btn: minute+1, 59->0 wrap, no carry into hour.
- Transition SET_MIN->RUN clears second to 0.
- day_pulse is never asserted by set-mode wraps.
- Simultaneous events:
  - mode_btn and inc_btn in the same cycle: mode transition taken, inc ignored.
  - tick and mode_btn in the same cycle while in RUN: tick is applied (time advances) and state moves to SET_HR.
  - inc_btn in RUN is ignored.
- Width rules: fields never exceed their maxima. Out-of-range INIT values are a parameter error, checked by an elaboration-time assertion.

Optional Feature:
- Macro ALARM_EN.
- Defined:
  - Adds alarm registers alm_hr and alm_min, both reset to 0.
  - State cycle becomes RUN->SET_HR->SET_MIN->SET_AHR(3'd3)->SET_AMIN(3'd4)->RUN; mode widens to 3 bits.
  - inc_btn in SET_AHR/SET_AMIN increments alm_hr (23->0) or alm_min (59->0).
  - alarm output is 1 while state==RUN and hour==alm_hr and minute==alm_min, otherwise 0; 0 at reset.
- Undefined: no alarm port, no alarm registers, 3-state cycle, mode is 2 bits.

Decomposition:
- Shared package contents:
  - State encoding constants (RUN, SET_HR, SET_MIN, SET_AHR, SET_AMIN).
  - Field limits HR_MAX=23 and MS_MAX=59.
  - Field widths HR_W=5 and MS_W=6, shared with the downstream converter.
- One sub-module, wrap_counter:
  - Parameterised width and max.
  - Inputs: inc, load value; output: carry (asserted when inc at max).
  - Instantiated for second, minute and hour, and for the alarm fields under ALARM_EN.

Test Plan:
- Reset with INIT_HR=0, INIT_MIN=0, apply 1 tick -> hour=0, minute=0, second=1, mode=0.
- Preset 23:59:59 via set mode plus 59 ticks, then 1 tick -> next cycle 00:00:00, day_pulse=1 for exactly one cycle.
- mode_btn once, inc_btn 25 times starting at hour=0 -> hour=1 (wraps after 23), minute and second unchanged; ticks during SET_HR do not move second.
- mode_btn twice, minute at 59, inc_btn -> minute=0 and hour unchanged; third mode_btn -> RUN, second=0.
- Same-cycle mode_btn+inc_btn in SET_HR at hour=5 -> state SET_MIN, hour stays 5. tick+mode_btn in RUN at 10:00:00 -> second=1, state SET_HR.
- ALARM_EN: set alm 07:30, run to 07:30:00 -> alarm=1 through 07:30:59, 0 at 07:31:00; assert rst mid-SET_AMIN -> RUN, alarm registers 0, alarm=0.
